issue_scheduler: RTL and testbench
==================================

// Module: issue_scheduler
// PURPOSE
//  N-lane in-order issue scheduler; parametrised successor of the dual-lane scheduling assistant.
//  Holds one decoded fetch bundle of LANES instructions and issues the longest hazard-free in-order prefix each cycle.
//  Blocked lanes stay pending and issue on later cycles.
//  Multi-cycle writeback interlock is a per-register busy scoreboard.
//  Sits between decode (control_unit per lane) and the LANES datapaths.
// PARAMETERS
//  LANES   2   instructions per bundle / datapaths driven
//  NREGS   32  architectural registers; x0 is never a hazard
//  REG_W   5   register index width, $clog2(NREGS)
//  WB_LAT  2   cycles after issue before a written reg may be read; 0 disables the scoreboard
//  CNT_W   16  width of the stall counter
// PORTS
//  clk            in   1              clock, rising edge
//  n_rst          in   1              asynchronous active-low reset
//  in_valid       in   1              bundle offered
//  in_ready       out  1              bundle accepted when in_valid && in_ready
//  in_lane_valid  in   LANES          per-lane instruction present
//  in_wen         in   LANES          lane writes its rd
//  in_rd          in   LANES*REG_W    destination index per lane
//  in_rs1         in   LANES*REG_W    source 1 per lane; 0 = unused
//  in_rs2         in   LANES*REG_W    source 2 per lane; 0 = unused
//  flush          in   1              discard the held bundle
//  issue_en       out  LANES          lane i enabled this cycle (datapath_i_enable)
//  issue_rd       out  LANES*REG_W    held rd per lane (registered bundle fields)
//  issue_rs1      out  LANES*REG_W    held rs1 per lane
//  issue_rs2      out  LANES*REG_W    held rs2 per lane
//  dep_stall      out  1              pending != 0 && issue_en == 0
//  stall_cnt      out  CNT_W          saturating count of dep_stall cycles
// BEHAVIOUR
//  Reset (n_rst=0, async)
//   - pending=0, all bundle fields=0, all scoreboard counters=0, stall_cnt=0.
//   - Resulting outputs: issue_en=0, in_ready=1, dep_stall=0.
//   - Reset mid-bundle discards the bundle.
//  Issue rule (combinational from held state)
//   - Lane i issues iff pending[i], every lower pending lane issues this cycle, and none of its nonzero rs1/rs2 is busy.
//   - Lane i is also blocked if any lower lane issuing this cycle has wen && rd!=0 && rd equal to rs1, rs2 or (wen) rd of lane i.
//   - Non-pending lanes are transparent to the prefix.
//  Pending update (each clk edge)
//   - pending &= ~issue_en.
//  Bundle acceptance
//   - in_ready = (pending & ~issue_en) == 0, i.e. held bundle empty or fully issuing this cycle.
//   - On accept: load all fields, pending <= in_lane_valid.
//   - Earliest issue is the cycle after acceptance.
//   - Hazard-free code sustains one bundle per cycle.
//   - in_lane_valid==0 bundle: accepted and dropped, no issue.
//  Scoreboard: one counter per reg, width $clog2(WB_LAT+1)
//   - Issue with wen && rd!=0 loads WB_LAT; otherwise a nonzero counter decrements by 1 per cycle.
//   - busy = counter!=0; reg 0 is never busy.
//   - A load in the same cycle as a decrement of that reg: the load wins.
//  Flush (synchronous, highest priority)
//   - pending <= 0; issue_en forced 0 and in_ready forced 0 that cycle.
//   - Scoreboard keeps counting; in-flight writes stay tracked.
//  Stall counter
//   - stall_cnt += dep_stall; saturates at all-ones; not cleared by flush.
// STRUCTURE
//  Package sched_pkg:
//   - typedef logic [REG_W-1:0] reg_idx_t
//   - typedef struct {valid, wen, rd, rs1, rs2} lane_ins_t
//   - localparam REG_ZERO
//  Sub-module reg_scoreboard (NREGS, WB_LAT):
//   - Inputs: set-enable vector and rd per lane.
//   - Outputs: busy per source query.
//  Top: bundle register, prefix/hazard logic (generate loop over lanes), stall counter.
// TESTING (LANES=2, WB_LAT=2)
//  - Independent lanes {x1=x2+x3 | x4=x5+x6} back-to-back:
//    issue_en=2'b11 every cycle, in_ready stays 1, dep_stall=0.
//  - Intra-bundle RAW {x1<-.. | ..<-x1}, bundle accepted at edge t:
//    issue_en=01 in cycle t+1, 00 in t+2 and t+3 (x1 busy), 10 in t+4; stall_cnt=2; in_ready=0 until t+4.
//  - WAW {x7<-.. | x7<-..}: issue_en=01, then lane1 waits 2 cycles, then issue_en=10.
//  - x0 destination {x0<-.. | ..<-x0}: issue_en=11 in one cycle.
//  - in_lane_valid=2'b01: only issue_en=01; in_ready=1 in the same cycle.
//  - flush during the RAW stall: next cycle issue_en=00 and in_ready=1; x1 counter still expires on schedule.
//  - n_rst pulse mid-stall: all outputs return to their reset values immediately.

Source files
------------

// File: rtl/sched_pkg.sv
// Shared types for the in-order issue scheduler: register index and one decoded lane slot.
package sched_pkg;

    localparam int SCHED_REG_W = 5;

    typedef logic [SCHED_REG_W-1:0] reg_idx_t;

    typedef struct packed {
        logic     valid;
        logic     wen;
        reg_idx_t rd;
        reg_idx_t rs1;
        reg_idx_t rs2;
    } lane_ins_t;

    localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register writeback countdown; a register reads as busy until WB_LAT cycles after its writer issued.
module reg_scoreboard #(
    parameter int LANES  = 2,
    parameter int NREGS  = 32,
    parameter int REG_W  = 5,
    parameter int WB_LAT = 2,
    parameter int NQ     = 4
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic [LANES-1:0]            set_en,
    input  logic [LANES-1:0][REG_W-1:0] set_rd,
    input  logic [NQ-1:0][REG_W-1:0]    query,
    output logic [NQ-1:0]               busy
);

    // WB_LAT == 0 loads zero, so every register simply never becomes busy.
    localparam int CW = (WB_LAT > 0) ? $clog2(WB_LAT + 1) : 1;

    logic [NREGS-1:0] reg_busy;

    for (genvar r = 0; r < NREGS; r++) begin : g_reg
        logic          load;
        logic [CW-1:0] cnt;

        always_comb begin
            load = 1'b0;
            for (int l = 0; l < LANES; l++)
                if (set_en[l] && set_rd[l] == REG_W'(r) && r != 0) load = 1'b1;
        end

        // A fresh issue overrides an in-progress countdown.
        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst)           cnt <= '0;
            else if (load)        cnt <= CW'(WB_LAT);
            else if (cnt != '0)   cnt <= cnt - 1'b1;
        end

        assign reg_busy[r] = (cnt != '0);
    end

    for (genvar q = 0; q < NQ; q++) begin : g_query
        assign busy[q] = reg_busy[query[q]];
    end

endmodule

// File: rtl/issue_scheduler.sv
// N-lane in-order issue scheduler: holds one decoded bundle and issues the longest hazard-free prefix per cycle.
module issue_scheduler
    import sched_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int NREGS  = 32,
    parameter int REG_W  = 5,
    parameter int WB_LAT = 2,
    parameter int CNT_W  = 16
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES-1:0]            in_lane_valid,
    input  logic [LANES-1:0]            in_wen,
    input  logic [LANES-1:0][REG_W-1:0] in_rd,
    input  logic [LANES-1:0][REG_W-1:0] in_rs1,
    input  logic [LANES-1:0][REG_W-1:0] in_rs2,
    input  logic                        flush,
    output logic [LANES-1:0]            issue_en,
    output logic [LANES-1:0][REG_W-1:0] issue_rd,
    output logic [LANES-1:0][REG_W-1:0] issue_rs1,
    output logic [LANES-1:0][REG_W-1:0] issue_rs2,
    output logic                        dep_stall,
    output logic [CNT_W-1:0]            stall_cnt
);

    if (REG_W != SCHED_REG_W) begin : g_width_check
        $error("issue_scheduler: REG_W must match sched_pkg::SCHED_REG_W");
    end

    lane_ins_t [LANES-1:0]              held;
    logic      [LANES-1:0]              pending;
    logic      [LANES-1:0]              issue_raw;
    logic      [LANES-1:0]              hazard;
    logic      [2*LANES-1:0][REG_W-1:0] query;
    logic      [2*LANES-1:0]            src_busy;
    logic                               prefix_ok;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign pending[i]    = held[i].valid;
        assign issue_rd[i]   = held[i].rd;
        assign issue_rs1[i]  = held[i].rs1;
        assign issue_rs2[i]  = held[i].rs2;
        assign query[2*i]    = held[i].rs1;
        assign query[2*i+1]  = held[i].rs2;
    end

    reg_scoreboard #(
        .LANES (LANES),
        .NREGS (NREGS),
        .REG_W (REG_W),
        .WB_LAT(WB_LAT),
        .NQ    (2*LANES)
    ) u_sb (
        .clk   (clk),
        .n_rst (n_rst),
        .set_en(issue_en & in_wen_held()),
        .set_rd(issue_rd),
        .query (query),
        .busy  (src_busy)
    );

    function automatic logic [LANES-1:0] in_wen_held();
        logic [LANES-1:0] w;
        for (int i = 0; i < LANES; i++) w[i] = held[i].wen;
        return w;
    endfunction

    // Prefix walk: a blocked pending lane stops everything above it; empty slots are skipped.
    always_comb begin
        issue_raw = '0;
        hazard    = '0;
        prefix_ok = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            hazard[i] = src_busy[2*i] | src_busy[2*i+1];
            for (int j = 0; j < i; j++)
                if (issue_raw[j] && held[j].wen && held[j].rd != REG_ZERO &&
                    (held[j].rd == held[i].rs1 || held[j].rd == held[i].rs2 ||
                     (held[i].wen && held[j].rd == held[i].rd)))
                    hazard[i] = 1'b1;
            if (held[i].valid) begin
                issue_raw[i] = prefix_ok && !hazard[i];
                prefix_ok    = prefix_ok && !hazard[i];
            end
        end
    end

    assign issue_en  = flush ? '0 : issue_raw;
    assign in_ready  = !flush && ((pending & ~issue_en) == '0);
    assign dep_stall = (pending != '0) && (issue_en == '0);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            held <= '0;
        end else if (flush) begin
            for (int i = 0; i < LANES; i++) held[i].valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            for (int i = 0; i < LANES; i++)
                held[i] <= '{valid: in_lane_valid[i], wen: in_wen[i],
                             rd: in_rd[i], rs1: in_rs1[i], rs2: in_rs2[i]};
        end else begin
            for (int i = 0; i < LANES; i++)
                if (issue_en[i]) held[i].valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            stall_cnt <= '0;
        else if (dep_stall && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler (LANES=2, WB_LAT=2) with a per-cycle expectation queue.
module tb_issue_scheduler;

    logic            clk = 1'b0;
    logic            n_rst;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_lane_valid;
    logic [1:0]      in_wen;
    logic [1:0][4:0] in_rd;
    logic [1:0][4:0] in_rs1;
    logic [1:0][4:0] in_rs2;
    logic            flush;
    logic [1:0]      issue_en;
    logic [1:0][4:0] issue_rd;
    logic [1:0][4:0] issue_rs1;
    logic [1:0][4:0] issue_rs2;
    logic            dep_stall;
    logic [15:0]     stall_cnt;

    typedef struct {
        logic [1:0] en;
        logic       rdy;
        logic       ds;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    issue_scheduler #(
        .LANES(2), .NREGS(32), .REG_W(5), .WB_LAT(2), .CNT_W(16)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_lane_valid(in_lane_valid),
        .in_wen       (in_wen),
        .in_rd        (in_rd),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .flush        (flush),
        .issue_en     (issue_en),
        .issue_rd     (issue_rd),
        .issue_rs1    (issue_rs1),
        .issue_rs2    (issue_rs2),
        .dep_stall    (dep_stall),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bundle(input logic [1:0] lv, input logic [1:0] w,
                          input logic [4:0] rd0, input logic [4:0] a0, input logic [4:0] b0,
                          input logic [4:0] rd1, input logic [4:0] a1, input logic [4:0] b1);
        in_valid      = 1'b1;
        in_lane_valid = lv;
        in_wen        = w;
        in_rd[0] = rd0; in_rs1[0] = a0; in_rs2[0] = b0;
        in_rd[1] = rd1; in_rs1[1] = a1; in_rs2[1] = b1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    // Called right after a negedge with this cycle's inputs driven; ends at the next negedge.
    task automatic chk(input string tag, input logic [1:0] en, input logic rdy, input logic ds);
        exp_t e;
        exp_t x;
        e.en = en; e.rdy = rdy; e.ds = ds;
        exp_q.push_back(e);
        #1;
        x = exp_q.pop_front();
        cmp({tag, ".issue_en"},  16'(issue_en),  16'(x.en));
        cmp({tag, ".in_ready"},  16'(in_ready),  16'(x.rdy));
        cmp({tag, ".dep_stall"}, 16'(dep_stall), 16'(x.ds));
        @(negedge clk);
    endtask

    initial begin
        n_rst = 1'b0;
        in_valid = 1'b0; flush = 1'b0;
        in_lane_valid = '0; in_wen = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        @(negedge clk); @(negedge clk);
        #1;
        cmp("reset.issue_en",  16'(issue_en),  16'h0);
        cmp("reset.in_ready",  16'(in_ready),  16'h1);
        cmp("reset.dep_stall", 16'(dep_stall), 16'h0);
        cmp("reset.stall_cnt", stall_cnt,      16'h0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        // Independent bundles back-to-back
        bundle(2'b11, 2'b11, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6);
        chk("indep.c0", 2'b00, 1'b1, 1'b0);
        chk("indep.c1", 2'b11, 1'b1, 1'b0);
        chk("indep.c2", 2'b11, 1'b1, 1'b0);
        idle();
        chk("indep.c3", 2'b11, 1'b1, 1'b0);
        chk("indep.c4", 2'b00, 1'b1, 1'b0);
        chk("indep.c5", 2'b00, 1'b1, 1'b0);

        // Intra-bundle RAW on x1
        bundle(2'b11, 2'b11, 5'd1, 5'd2, 5'd3, 5'd8, 5'd1, 5'd0);
        chk("raw.t", 2'b00, 1'b1, 1'b0);
        idle();
        chk("raw.t1", 2'b01, 1'b0, 1'b0);
        chk("raw.t2", 2'b00, 1'b0, 1'b1);
        chk("raw.t3", 2'b00, 1'b0, 1'b1);
        #1 cmp("raw.stall_cnt", stall_cnt, 16'd2);
        chk("raw.t4", 2'b10, 1'b1, 1'b0);

        // WAW on x7; lane1 also reads x7
        bundle(2'b11, 2'b11, 5'd7, 5'd2, 5'd3, 5'd7, 5'd7, 5'd3);
        chk("waw.t", 2'b00, 1'b1, 1'b0);
        idle();
        chk("waw.t1", 2'b01, 1'b0, 1'b0);
        chk("waw.t2", 2'b00, 1'b0, 1'b1);
        chk("waw.t3", 2'b00, 1'b0, 1'b1);
        chk("waw.t4", 2'b10, 1'b1, 1'b0);

        // x0 is never a hazard
        bundle(2'b11, 2'b11, 5'd0, 5'd2, 5'd3, 5'd9, 5'd0, 5'd0);
        chk("x0.t", 2'b00, 1'b1, 1'b0);
        idle();
        chk("x0.t1", 2'b11, 1'b1, 1'b0);

        // Only lane 0 present; lane 1 slot would otherwise hazard on x10
        bundle(2'b01, 2'b11, 5'd10, 5'd2, 5'd3, 5'd12, 5'd10, 5'd10);
        chk("lv01.t", 2'b00, 1'b1, 1'b0);
        idle();
        chk("lv01.t1", 2'b01, 1'b1, 1'b0);

        // Empty bundle is accepted and dropped
        bundle(2'b00, 2'b11, 5'd13, 5'd2, 5'd3, 5'd14, 5'd2, 5'd3);
        chk("lv00.t", 2'b00, 1'b1, 1'b0);
        idle();
        chk("lv00.t1", 2'b00, 1'b1, 1'b0);
        #1 cmp("lv00.stall_cnt", stall_cnt, 16'd4);

        // Flush during the RAW stall; x1 countdown keeps running
        bundle(2'b11, 2'b11, 5'd1, 5'd2, 5'd3, 5'd8, 5'd1, 5'd0);
        chk("fl.t", 2'b00, 1'b1, 1'b0);
        idle();
        chk("fl.t1", 2'b01, 1'b0, 1'b0);
        flush = 1'b1;
        chk("fl.t2", 2'b00, 1'b0, 1'b1);
        flush = 1'b0;
        bundle(2'b01, 2'b01, 5'd11, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0);
        chk("fl.t3", 2'b00, 1'b1, 1'b0);
        idle();
        chk("fl.t4", 2'b01, 1'b1, 1'b0);
        #1 cmp("fl.stall_cnt", stall_cnt, 16'd5);

        // Async reset pulse mid-stall
        bundle(2'b11, 2'b11, 5'd1, 5'd2, 5'd3, 5'd8, 5'd1, 5'd0);
        chk("rst.u", 2'b00, 1'b1, 1'b0);
        idle();
        chk("rst.u1", 2'b01, 1'b0, 1'b0);
        chk("rst.u2", 2'b00, 1'b0, 1'b1);
        #1 cmp("rst.pre_cnt", stall_cnt, 16'd6);
        #1 n_rst = 1'b0;
        #1;
        cmp("rst.issue_en",  16'(issue_en),  16'h0);
        cmp("rst.in_ready",  16'(in_ready),  16'h1);
        cmp("rst.dep_stall", 16'(dep_stall), 16'h0);
        cmp("rst.stall_cnt", stall_cnt,      16'h0);
        @(negedge clk);
        n_rst = 1'b1;
        chk("rst.after", 2'b00, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
